// File: rtl/m8088_bus_pkg.sv
// Shared types and defaults for the m8088 external bus arbiter.
package m8088_bus_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 8;

  // Arbiter sequencing: HOLD handshake, strobed access (T1/T2/DONE),
  // continue-or-release decision, then handback to the CPU.
  typedef enum logic [2:0] {
    IDLE,
    HOLD_REQ,
    T1,
    T2,
    DONE,
    NEXT,
    RELEASE
  } state_e;

endpackage

// File: rtl/m8088_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first pending request strictly
// after `last` (wrapping) wins; the last owner itself is checked last.
module rr_pick
  import m8088_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt
);

  logic          found;
  logic [LW-1:0] idx;

  // Walk the requesters starting one past the last owner.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m8088_bus_arbiter.sv
// m8088 external bus arbiter: takes the bus from the CPU via HOLD/HOLDA,
// shares it round-robin between secondary masters and runs each access as
// a T1/T2/DONE strobed cycle with READY wait states. All outputs registered.
module m8088_bus_arbiter
  import m8088_bus_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_XFER = 16
) (
  input  logic                      CORE_CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ-1:0]        REQ_WE,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        ACK,
  output logic [DATA_W-1:0]         RDATA,
  output logic                      CPU_HOLD,
  input  logic                      CPU_HOLDA,
  output logic                      BUS_OE,
  output logic [ADDR_W-1:0]         BUS_ADDR,
  output logic [DATA_W-1:0]         BUS_DOUT,
  input  logic [DATA_W-1:0]         BUS_DIN,
  output logic                      BUS_RD_n,
  output logic                      BUS_WR_n,
  input  logic                      BUS_READY
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_XFER + 1);

  state_e              state_q, state_d;
  // last_q is both the round-robin pointer and the current owner index.
  logic [LW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                load;

  logic [NUM_REQ-1:0]  pick;
  logic [LW-1:0]       pick_idx;
  logic                any_req;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dout_q, rdata_q;
  logic [NUM_REQ-1:0]  gnt_q, ack_q;
  logic                hold_q, oe_q, rd_n_q, wr_n_q;
  logic                own_bus_d;

  assign any_req = |REQ;

  rr_pick #(.NUM_REQ(NUM_REQ), .LW(LW)) u_pick (
    .req  (REQ),
    .last (last_q),
    .gnt  (pick)
  );

  // One-hot winner to index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = LW'(i);
  end

  // Mux the request fields of whoever owns the bus next.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_d == LW'(i)) begin
        sel_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
        sel_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
        sel_we    = REQ_WE[i];
      end
    end
  end

  // Next-state, owner selection and tenure counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE:     if (any_req) state_d = HOLD_REQ;
      HOLD_REQ: begin
        if (!any_req) begin
          state_d = RELEASE;
        end else if (CPU_HOLDA) begin
          state_d = T1;
          last_d  = pick_idx;
          load    = 1'b1;
        end
      end
      T1:       state_d = T2;
      T2:       if (BUS_READY) state_d = DONE;
      DONE:     state_d = NEXT;
      NEXT: begin
        // Losing HOLDA or hitting the tenure cap both force a handback.
        if (!CPU_HOLDA || cnt_q >= CW'(MAX_XFER)) begin
          state_d = RELEASE;
        end else if (REQ[last_q]) begin
          state_d = T1;
          load    = 1'b1;
        end else if (any_req) begin
          state_d = T1;
          last_d  = pick_idx;
          load    = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE:  if (!CPU_HOLDA) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d == IDLE)
      cnt_d = '0;
    else if (state_q == DONE && cnt_q < CW'(MAX_XFER))
      cnt_d = cnt_q + 1'b1;

    own_bus_d = (state_d == T1) || (state_d == T2) ||
                (state_d == DONE) || (state_d == NEXT);
  end

  // State plus all outputs, registered from the next state.
  always_ff @(posedge CORE_CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= LW'(NUM_REQ - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      hold_q  <= 1'b0;
      oe_q    <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q <= sel_addr;
        dout_q <= sel_wdata;
        we_q   <= sel_we;
      end
      if (state_q == T2 && BUS_READY && !we_q)
        rdata_q <= BUS_DIN;
      gnt_q  <= own_bus_d ? (NUM_REQ'(1) << last_d) : '0;
      ack_q  <= (state_d == DONE) ? (NUM_REQ'(1) << last_q) : '0;
      hold_q <= own_bus_d || (state_d == HOLD_REQ);
      oe_q   <= own_bus_d;
      rd_n_q <= !(state_d == T2 && !we_q);
      wr_n_q <= !(state_d == T2 && we_q);
    end
  end

  assign GNT      = gnt_q;
  assign ACK      = ack_q;
  assign RDATA    = rdata_q;
  assign CPU_HOLD = hold_q;
  assign BUS_OE   = oe_q;
  assign BUS_ADDR = addr_q;
  assign BUS_DOUT = dout_q;
  assign BUS_RD_n = rd_n_q;
  assign BUS_WR_n = wr_n_q;

endmodule

// File: tb/tb_m8088_bus_arbiter.sv
// Directed bench for m8088_bus_arbiter: a simple CPU model returns HOLDA
// one cycle after HOLD; everything else is driven step by step.
module tb_m8088_bus_arbiter;

  logic        CORE_CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ, REQ_WE;
  logic [39:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic [1:0]  GNT, ACK;
  logic [7:0]  RDATA;
  logic        CPU_HOLD;
  logic        CPU_HOLDA = 1'b0;
  logic        BUS_OE;
  logic [19:0] BUS_ADDR;
  logic [7:0]  BUS_DOUT, BUS_DIN;
  logic        BUS_RD_n, BUS_WR_n, BUS_READY;

  logic        cpu_en = 1'b1;
  int          nvec = 0, nerr = 0;

  m8088_bus_arbiter #(.NUM_REQ(2), .ADDR_W(20), .DATA_W(8), .MAX_XFER(16)) dut (
    .CORE_CLK  (CORE_CLK),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .GNT       (GNT),
    .ACK       (ACK),
    .RDATA     (RDATA),
    .CPU_HOLD  (CPU_HOLD),
    .CPU_HOLDA (CPU_HOLDA),
    .BUS_OE    (BUS_OE),
    .BUS_ADDR  (BUS_ADDR),
    .BUS_DOUT  (BUS_DOUT),
    .BUS_DIN   (BUS_DIN),
    .BUS_RD_n  (BUS_RD_n),
    .BUS_WR_n  (BUS_WR_n),
    .BUS_READY (BUS_READY)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  // CPU: acknowledges HOLD one cycle later (when enabled).
  always @(posedge CORE_CLK) CPU_HOLDA <= cpu_en ? CPU_HOLD : 1'b0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic t();
    @(negedge CORE_CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] ackseq [4];
  int         ackcyc [4];
  logic [1:0] dropm, gor;
  int         nack, gap;
  logic       done_f;

  initial begin
    RESET = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    BUS_DIN = '0; BUS_READY = 1'b1;
    repeat (3) t();
    // Reset state
    chk("rst_hold",  32'(CPU_HOLD), 0);
    chk("rst_gnt",   32'(GNT), 0);
    chk("rst_ack",   32'(ACK), 0);
    chk("rst_oe",    32'(BUS_OE), 0);
    chk("rst_strb",  32'({BUS_RD_n, BUS_WR_n}), 32'h3);
    chk("rst_addr",  32'(BUS_ADDR), 0);
    chk("rst_dout",  32'(BUS_DOUT), 0);
    chk("rst_rdata", 32'(RDATA), 0);
    RESET = 1'b0;
    t();

    // 1: read 0x12345 by requester 0, no wait states
    REQ = 2'b01; REQ_WE = 2'b00; REQ_ADDR[19:0] = 20'h12345;
    BUS_READY = 1'b1; BUS_DIN = 8'hA5;
    t(); chk("t1_hold", 32'(CPU_HOLD), 1); chk("t1_gnt_hreq", 32'(GNT), 0);
    t();
    t(); chk("t1_gnt", 32'(GNT), 32'h1); chk("t1_addr", 32'(BUS_ADDR), 32'h12345);
         chk("t1_oe", 32'(BUS_OE), 1); chk("t1_rd_t1", 32'(BUS_RD_n), 1);
    t(); chk("t1_rd_low", 32'(BUS_RD_n), 0); chk("t1_wr_hi", 32'(BUS_WR_n), 1);
    t(); chk("t1_ack", 32'(ACK), 32'h1); chk("t1_rdata", 32'(RDATA), 32'hA5);
         chk("t1_rd_hi", 32'(BUS_RD_n), 1);
    REQ = 2'b00;
    t(); chk("t1_ack_pulse", 32'(ACK), 0);
    t(); chk("t1_rel_hold", 32'(CPU_HOLD), 0); chk("t1_rel_oe", 32'(BUS_OE), 0);
         chk("t1_rel_gnt", 32'(GNT), 0);
    repeat (4) t();

    // 2: write 0x3C to 0x00400 by requester 1, READY low 3 cycles
    REQ = 2'b10; REQ_WE = 2'b10; REQ_ADDR[39:20] = 20'h00400; REQ_WDATA[15:8] = 8'h3C;
    BUS_READY = 1'b0;
    t(); t();
    t(); chk("t2_gnt", 32'(GNT), 32'h2); chk("t2_addr", 32'(BUS_ADDR), 32'h00400);
         chk("t2_wr_t1", 32'(BUS_WR_n), 1);
    for (int i = 0; i < 4; i++) begin
      t(); chk("t2_wr_low", 32'(BUS_WR_n), 0); chk("t2_dout", 32'(BUS_DOUT), 32'h3C);
           chk("t2_no_ack", 32'(ACK), 0);
      if (i == 3) BUS_READY = 1'b1;
    end
    t(); chk("t2_ack", 32'(ACK), 32'h2); chk("t2_wr_hi", 32'(BUS_WR_n), 1);
         chk("t2_rdata_kept", 32'(RDATA), 32'hA5);
    REQ = 2'b00; REQ_WE = 2'b00;
    repeat (6) t();
    chk("t2_released", 32'(CPU_HOLD), 0);

    // 3: both requesting; each drops REQ through NEXT after its ACK
    REQ_ADDR[19:0] = 20'h11111; REQ_ADDR[39:20] = 20'h22222;
    REQ = 2'b11; dropm = 2'b00; nack = 0;
    for (int c = 0; c < 80 && nack < 4; c++) begin
      t();
      if (ACK != 2'b00) begin ackseq[nack] = ACK; ackcyc[nack] = c; nack++; end
      REQ = 2'b11 & ~ACK & ~dropm;
      dropm = ACK;
    end
    REQ = 2'b00;
    chk("t3_nack", 32'(nack), 4);
    chk("t3_own0", 32'(ackseq[0]), 32'h1);
    chk("t3_own1", 32'(ackseq[1]), 32'h2);
    chk("t3_own2", 32'(ackseq[2]), 32'h1);
    chk("t3_own3", 32'(ackseq[3]), 32'h2);
    chk("t3_b2b", 32'(ackcyc[1] - ackcyc[0]), 4);
    repeat (6) t();
    chk("t3_released", 32'(CPU_HOLD), 0);

    // 4: requester 0 held high -> tenure cap of 16, then re-request
    REQ = 2'b01; BUS_READY = 1'b1; nack = 0; done_f = 1'b0;
    for (int c = 0; c < 200; c++) begin
      t();
      if (ACK[0]) nack++;
      if (!CPU_HOLD && nack > 0) begin done_f = 1'b1; break; end
    end
    chk("t4_released", 32'(done_f), 1);
    chk("t4_nack", 32'(nack), 16);
    gap = 0;
    for (int c = 0; c < 20; c++) begin
      t(); gap++;
      if (CPU_HOLD) break;
    end
    chk("t4_rehold_gap", 32'(gap), 3);

    // 5: reset during T2
    BUS_READY = 1'b0; done_f = 1'b0;
    for (int c = 0; c < 20; c++) begin
      t();
      if (!BUS_RD_n) begin done_f = 1'b1; break; end
    end
    chk("t5_in_t2", 32'(done_f), 1);
    RESET = 1'b1;
    t(); chk("t5_strb", 32'({BUS_RD_n, BUS_WR_n}), 32'h3); chk("t5_oe", 32'(BUS_OE), 0);
         chk("t5_hold", 32'(CPU_HOLD), 0); chk("t5_ack", 32'(ACK), 0);
         chk("t5_gnt", 32'(GNT), 0); chk("t5_rdata", 32'(RDATA), 0);
    RESET = 1'b0; REQ = 2'b00; BUS_READY = 1'b1;
    t(); chk("t5_no_ack", 32'(ACK), 0);
    repeat (4) t();

    // 6: REQ withdrawn while waiting for HOLDA
    cpu_en = 1'b0;
    t();
    REQ = 2'b01; gor = 2'b00;
    t(); chk("t6_hold", 32'(CPU_HOLD), 1); gor |= GNT;
    REQ = 2'b00;
    t(); chk("t6_release", 32'(CPU_HOLD), 0); gor |= GNT;
    repeat (3) begin t(); gor |= GNT; end
    chk("t6_never_gnt", 32'(gor), 0);
    chk("t6_idle_hold", 32'(CPU_HOLD), 0);

    // 7: after reset, requester 0 wins a tie
    cpu_en = 1'b1; REQ = 2'b11; done_f = 1'b0;
    for (int c = 0; c < 20; c++) begin
      t();
      if (GNT != 2'b00) begin done_f = 1'b1; break; end
    end
    chk("t7_granted", 32'(done_f), 1);
    chk("t7_first_owner", 32'(GNT), 32'h1);
    REQ = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
